window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator that drains the grayscale frame FIFO and feeds the Sobel gradient stage. It pops one pixel per cycle from the FIFO's read port, tracks the raster position, and keeps the two previous rows in line buffers. For every interior pixel position it presents a registered 3x3 window with a valid/ready handshake toward the Sobel stage.

## Interface
- WIDTH, 8, bits per pixel
- HEIGHT, 480, rows per frame (>= 3)
- LENGTH, 640, columns per row (>= 3)
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- fifo_empty  input  1  FIFO empty flag
- fifo_dout  input  WIDTH  FIFO read data; valid in the same cycle as fifo_rd_en && !fifo_empty
- fifo_rd_en  output  1  FIFO pop request
- win_ready  input  1  Sobel stage accepts the window this cycle
- win_valid  output  1  win_data/win_row/win_col valid
- win_data  output  9*WIDTH  window; element k = 3*i + j at bits [k*WIDTH +: WIDTH]; i = row offset (0 = oldest row), j = column offset (0 = leftmost); k = 4 is the centre
- win_row  output  clog2(HEIGHT)  centre row of the presented window
- win_col  output  clog2(LENGTH)  centre column of the presented window
- frame_done  output  1  one-cycle pulse when the last window of a frame is loaded

## Operation
- Accept = fifo_rd_en && !fifo_empty. Only an accepted pixel advances any state.
- fifo_rd_en = rst_n && (!win_valid || win_ready). This is a one-entry output register with pass-through on ready. It is 0 while rst_n is low.
- Position counters col (0..LENGTH-1) and row (0..HEIGHT-1) give the raster position of the pixel being accepted.
  - col increments per accept and wraps to 0 after LENGTH-1, which increments row.
  - row wraps to 0 after HEIGHT-1, starting the next frame with no gap.
- Line buffers: two LENGTH x WIDTH memories, lb1 (row-1) and lb2 (row-2), addressed by col.
  - On accept: lb2[col] <= lb1[col] and lb1[col] <= fifo_dout.
  - Reads are either asynchronous or pre-fetched; a read-before-write result at the same col is required.
- Column shift registers: three columns of 3 pixels (oldest row, middle row, current). On accept, shift left by one column and load {lb2[col], lb1[col], fifo_dout} into column j=2.
- Window emission: an accept at (row, col) with row >= 2 and col >= 2 loads the output register on that edge.
  - win_data covers rows row-2..row and columns col-2..col, including the newly accepted pixel.
  - win_row = row-1 and win_col = col-1. win_valid <= 1.
- No border windows are produced. A frame yields exactly (HEIGHT-2)*(LENGTH-2) windows.
- If no window is loaded and win_ready is 1, win_valid <= 0. Output fields hold their value while win_valid && !win_ready.
- frame_done is 1 for one cycle exactly when the window for accept (HEIGHT-1, LENGTH-1) is loaded.
- There is no control FSM beyond the counters. Line-buffer memories are not reset. Their stale contents never reach a window, because row >= 2 guarantees both rows were written this frame.

## Timing
- Reset (asynchronous, rst_n low) clears row, col, the shift registers, win_valid, win_data, win_row, win_col and frame_done to 0. fifo_rd_en is 0 during reset.
- Reset mid-frame: the partial frame is discarded, and the first accept after release is pixel (0,0).
- Latency: a window becomes visible on win_valid the cycle after the accept of its bottom-right pixel.
- Throughput: one pixel and one window per cycle when fifo_empty = 0 and win_ready = 1.
- Backpressure: if win_valid && !win_ready, then fifo_rd_en = 0, no accept occurs, and all state freezes.
- fifo_empty gaps insert bubbles. win_valid drops only after the held window is taken.
- A simultaneous take (win_ready) and new load in the same cycle replaces the window without a bubble.
- Frame wrap: the accept of (0,0) immediately after (HEIGHT-1, LENGTH-1) needs no idle cycle.

## Test plan
- HEIGHT=4, LENGTH=5, continuous stream with pixel value 10*r+c and win_ready=1:
  - expect 6 windows with centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
  - The first window is {0,1,2,10,11,12,20,21,22}, k=0..8, visible one cycle after the accept of (2,2).
  - frame_done pulses with the (2,3) window.
- Same stream with win_ready held 0 for 5 cycles after the first window: the window {0..22} holds steady, fifo_rd_en=0, and no pixel is lost. After release the remaining 5 windows arrive in order.
- fifo_empty toggled pseudo-randomly (50%): the window contents and order are identical to the continuous case, with no window emitted on a non-accept cycle.
- Two back-to-back frames with frame 2 values = 10*r+c+100: frame 2's first window is {100,101,102,110,...,122}, with no contamination from frame 1.
- rst_n pulsed low after 12 accepts, then a fresh frame: all outputs read 0 during reset, and the first post-reset window again equals {0,1,2,10,11,12,20,21,22}.
- Default 480x640 stream with random data: exactly 478*638 windows, each matching a software reference model.

Source files
------------

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Streaming 3x3 neighbourhood generator. It pops one grayscale pixel per cycle
// from the frame FIFO and tracks the raster position of that pixel. Two line
// buffers hold the previous rows. For every interior pixel it presents a
// registered 3x3 window, with a valid/ready handshake, to the Sobel stage.
//
// Window packing: element k = 3*i + j sits at win_data[k*WIDTH +: WIDTH].
// i is the row offset (0 = oldest row). j is the column offset (0 = leftmost).
// k = 4 is the centre pixel.

module window_3x3_gen #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 480,
    parameter int LENGTH = 640,
    localparam int RW    = $clog2(HEIGHT),
    localparam int CW    = $clog2(LENGTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_dout,
    output logic               fifo_rd_en,
    input  logic               win_ready,
    output logic               win_valid,
    output logic [9*WIDTH-1:0] win_data,
    output logic [RW-1:0]      win_row,
    output logic [CW-1:0]      win_col,
    output logic               frame_done
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The output stage is a single register. A new pixel may be popped
    // whenever that register is empty, or is being drained in this cycle.
    logic win_valid_reg;
    logic accept;

    assign fifo_rd_en = rst_n && (!win_valid_reg || win_ready);
    assign accept     = fifo_rd_en && !fifo_empty;

    // ------------------------------------------------------------------
    // Raster position of the pixel being accepted
    // ------------------------------------------------------------------
    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic          last_col;
    logic          last_row;

    assign last_col = (col_reg == CW'(LENGTH - 1));
    assign last_row = (row_reg == RW'(HEIGHT - 1));

    // Next-position logic: col wraps into row, row wraps into the next frame.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (last_col) begin
                col_next = '0;
                row_next = last_row ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    // Position register. Reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row-1 and lb2 holds row-2, both indexed by column.
    // ------------------------------------------------------------------
    // Reads are asynchronous, so the old contents at col are seen in the same
    // cycle that they are overwritten. The memories are never reset. Any window
    // with row >= 2 has had both of its rows written during the current frame.
    logic [WIDTH-1:0] lb1_mem [LENGTH];
    logic [WIDTH-1:0] lb2_mem [LENGTH];
    logic [WIDTH-1:0] lb1_rd;
    logic [WIDTH-1:0] lb2_rd;

    assign lb1_rd = lb1_mem[col_reg];
    assign lb2_rd = lb2_mem[col_reg];

    // Line-buffer update: row-1 moves down to row-2, and the new pixel becomes row-1.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_mem[col_reg] <= lb1_rd;
            lb1_mem[col_reg] <= fifo_dout;
        end
    end

    // ------------------------------------------------------------------
    // Column shift registers
    // ------------------------------------------------------------------
    // new_col is the incoming column. Index 0 is the oldest row and index 2 is
    // the current pixel. The new column itself forms the right-hand column of
    // the window. Only the two older columns need storage: col_c_reg is the
    // column at col-1 and col_b_reg is the column at col-2.
    logic [2:0][WIDTH-1:0] new_col;
    logic [2:0][WIDTH-1:0] col_b_reg;
    logic [2:0][WIDTH-1:0] col_c_reg;

    assign new_col = {fifo_dout, lb1_rd, lb2_rd};

    // Shift left by one column on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_b_reg <= '0;
            col_c_reg <= '0;
        end else if (accept) begin
            col_b_reg <= col_c_reg;
            col_c_reg <= new_col;
        end
    end

    // ------------------------------------------------------------------
    // Window assembly: rows row-2..row, columns col-2..col
    // ------------------------------------------------------------------
    logic [9*WIDTH-1:0] win_next;

    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        assign win_next[(3*gi + 0)*WIDTH +: WIDTH] = col_b_reg[gi];
        assign win_next[(3*gi + 1)*WIDTH +: WIDTH] = col_c_reg[gi];
        assign win_next[(3*gi + 2)*WIDTH +: WIDTH] = new_col[gi];
    end

    // A window exists only where a full 3x3 neighbourhood is available.
    logic load;
    assign load = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [9*WIDTH-1:0] win_data_reg;
    logic [RW-1:0]      win_row_reg;
    logic [CW-1:0]      win_col_reg;
    logic               frame_done_reg;

    // Output register: load on an interior accept, clear valid when the window
    // is taken, and hold the window while it is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg  <= 1'b0;
            win_data_reg   <= '0;
            win_row_reg    <= '0;
            win_col_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= load && last_row && last_col;
            if (load) begin
                win_valid_reg <= 1'b1;
                win_data_reg  <= win_next;
                win_row_reg   <= row_reg - RW'(1);
                win_col_reg   <= col_reg - CW'(1);
            end else if (win_ready) begin
                win_valid_reg <= 1'b0;
            end
        end
    end

    assign win_valid  = win_valid_reg;
    assign win_data   = win_data_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Testbench for window_3x3_gen on a 4x5 frame.
// A queue-based FIFO model drives the pixel stream. Each window taken by the
// sink is compared against an expected-window queue. For the 10*r+c frames that
// queue comes from a hand-written table; for the random frames it comes from a
// small reference model.

module tb_window_3x3_gen;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int L  = 5;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(L);

    logic            clk;
    logic            rst_n;
    logic            fifo_empty;
    logic [W-1:0]    fifo_dout;
    logic            fifo_rd_en;
    logic            win_ready;
    logic            win_valid;
    logic [9*W-1:0]  win_data;
    logic [RW-1:0]   win_row;
    logic [CW-1:0]   win_col;
    logic            frame_done;

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .LENGTH(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .win_ready  (win_ready),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int d[9];
    } win_rec_t;

    typedef struct {
        int             row;
        int             col;
        logic [9*W-1:0] data;
    } exp_t;

    typedef struct {
        int gap;
        int stall;
        int rnd;
        int frames;
    } scen_t;

    int       checks;
    int       errors;
    int       pix_q[$];
    exp_t     exp_q[$];
    win_rec_t win_tab[6];
    scen_t    scen[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue the pixels of one frame, together with the windows that frame is expected to produce.
    task automatic push_frame(input int off, input int rnd);
        int   fr[H][L];
        exp_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < L; c++) begin
                fr[r][c] = rnd ? int'($urandom_range(0, 255)) : 10*r + c + off;
                pix_q.push_back(fr[r][c]);
            end
        end
        if (!rnd) begin
            for (int t = 0; t < 6; t++) begin
                e.row  = win_tab[t].row;
                e.col  = win_tab[t].col;
                e.data = '0;
                for (int k = 0; k < 9; k++) e.data[k*W +: W] = W'(win_tab[t].d[k] + off);
                exp_q.push_back(e);
            end
        end else begin
            for (int r = 1; r < H-1; r++) begin
                for (int c = 1; c < L-1; c++) begin
                    e.row  = r;
                    e.col  = c;
                    e.data = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.data[(3*i+j)*W +: W] = W'(fr[r-1+i][c-1+j]);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Drive the queued pixels and take windows, checking every cycle.
    // lat is the number of cycles from the accept of pixel index 12 (pixel (2,2))
    // to the first new window.
    task automatic run_stream(input int gap, input int stall, output int lat, output int done_cnt);
        logic           prev_valid  = 1'b0;
        logic           prev_taken  = 1'b0;
        logic           prev_accept = 1'b0;
        logic [9*W-1:0] prev_data   = '0;
        int stall_left = stall ? 5 : 0;
        int taken      = 0;
        int acc        = 0;
        int acc_cyc    = -1;
        int first_cyc  = -1;
        int cyc;
        logic taken_now;
        logic acc_now;
        exp_t e;
        done_cnt = 0;
        for (cyc = 0; cyc < 3000 && (pix_q.size() > 0 || exp_q.size() > 0 || win_valid); cyc++) begin
            @(negedge clk);
            if (stall != 0 && taken == 0 && win_valid && stall_left > 0) begin
                win_ready  = 1'b0;
                stall_left--;
            end else begin
                win_ready = 1'b1;
            end
            fifo_empty = (pix_q.size() == 0) || (gap != 0 && $urandom_range(0, 1) == 1);
            fifo_dout  = fifo_empty ? W'($urandom) : W'(pix_q[0]);
            #1;
            if (win_valid && (!prev_valid || prev_taken)) begin
                check("new_win_needs_accept", 128'(prev_accept), 128'(1'b1));
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (win_valid && prev_valid && !prev_taken)
                check("stalled_win_hold", 128'(win_data), 128'(prev_data));
            if (frame_done) begin
                done_cnt++;
                check("frame_done_window", 128'({win_valid, win_row, win_col}),
                      128'({1'b1, RW'(H-2), CW'(L-2)}));
            end
            check("fifo_rd_en", 128'(fifo_rd_en), 128'(!win_valid || win_ready));
            taken_now = win_valid && win_ready;
            if (taken_now) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 128'(1'b1), 128'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    $display("win r=%0d c=%0d data=%h", win_row, win_col, win_data);
                    check("win_data", 128'(win_data), 128'(e.data));
                    check("win_pos", 128'({win_row, win_col}), 128'({RW'(e.row), CW'(e.col)}));
                end
                taken++;
            end
            acc_now = fifo_rd_en && !fifo_empty;
            if (acc_now) begin
                void'(pix_q.pop_front());
                acc++;
                if (acc == 13 && acc_cyc < 0) acc_cyc = cyc;
            end
            prev_valid  = win_valid;
            prev_taken  = taken_now;
            prev_accept = acc_now;
            prev_data   = win_data;
        end
        if (cyc >= 3000) check("stream_timeout", 128'(1'b1), 128'(1'b0));
        lat = first_cyc - acc_cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},      128'(win_valid),  128'(1'b0));
        check({tag, "_data"},       128'(win_data),   128'(0));
        check({tag, "_row_col"},    128'({win_row, win_col}), 128'(0));
        check({tag, "_frame_done"}, 128'(frame_done), 128'(1'b0));
        check({tag, "_rd_en"},      128'(fifo_rd_en), 128'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dn;
        checks = 0;
        errors = 0;

        // Hand-computed windows for a 4x5 frame with pixel value 10*r+c.
        win_tab[0] = '{1, 1, '{ 0,  1,  2, 10, 11, 12, 20, 21, 22}};
        win_tab[1] = '{1, 2, '{ 1,  2,  3, 11, 12, 13, 21, 22, 23}};
        win_tab[2] = '{1, 3, '{ 2,  3,  4, 12, 13, 14, 22, 23, 24}};
        win_tab[3] = '{2, 1, '{10, 11, 12, 20, 21, 22, 30, 31, 32}};
        win_tab[4] = '{2, 2, '{11, 12, 13, 21, 22, 23, 31, 32, 33}};
        win_tab[5] = '{2, 3, '{12, 13, 14, 22, 23, 24, 32, 33, 34}};

        // gap, stall, rnd, frames
        scen[0] = '{0, 0, 0, 1};
        scen[1] = '{0, 1, 0, 1};
        scen[2] = '{1, 0, 0, 1};
        scen[3] = '{0, 0, 0, 2};
        scen[4] = '{1, 0, 1, 2};

        rst_n      = 1'b0;
        win_ready  = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_reset_outputs("init_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 5; s++) begin
            for (int f = 0; f < scen[s].frames; f++) push_frame(100*f, scen[s].rnd);
            run_stream(scen[s].gap, scen[s].stall, lat, dn);
            check("frame_done_count", 128'(dn), 128'(scen[s].frames));
            check("pixels_left", 128'(pix_q.size()), 128'(0));
            check("windows_left", 128'(exp_q.size()), 128'(0));
            if (s == 0) check("first_window_latency", 128'(lat), 128'(1));
        end

        // Reset in mid-frame. Stream 13 pixels so that window (1,1) appears, then reset.
        for (int p = 0; p < 13; p++) pix_q.push_back(10*(p / L) + (p % L));
        exp_q.push_back('{1, 1, 72'h16_15_14_0C_0B_0A_02_01_00});
        run_stream(0, 0, lat, dn);
        check("partial_windows_left", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        fifo_dout  = 8'hAA;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        #1;
        check_reset_outputs("mid_reset_hold");
        @(negedge clk);
        rst_n      = 1'b1;
        fifo_empty = 1'b1;
        push_frame(0, 0);
        run_stream(0, 0, lat, dn);
        check("post_reset_frame_done", 128'(dn), 128'(1));
        check("post_reset_windows_left", 128'(exp_q.size()), 128'(0));
        check("post_reset_latency", 128'(lat), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
